// File: rtl/load_store_unit_if.sv
// Request/response and byte-wide memory bus bundle for the load/store unit.
// The LSU takes the slave view; the core/memory side takes the master view.
interface load_store_unit_if #(
    parameter int ADDRESS_WIDTH = 16
) ();

    logic                     request_valid;
    logic                     request_ready;
    logic                     request_write;
    logic [2:0]               request_funct3;
    logic [31:0]              request_address;
    logic [31:0]              request_store_data;

    logic                     response_valid;
    logic                     response_error;
    logic [31:0]              response_load_data;

    logic                     memory_valid;
    logic                     memory_ready;
    logic                     memory_write;
    logic [ADDRESS_WIDTH-1:0] memory_address;
    logic [7:0]               memory_write_data;
    logic [7:0]               memory_read_data;

    modport slave (
        input  request_valid,
        output request_ready,
        input  request_write,
        input  request_funct3,
        input  request_address,
        input  request_store_data,
        output response_valid,
        output response_error,
        output response_load_data,
        output memory_valid,
        input  memory_ready,
        output memory_write,
        output memory_address,
        output memory_write_data,
        input  memory_read_data
    );

    modport master (
        output request_valid,
        input  request_ready,
        output request_write,
        output request_funct3,
        output request_address,
        output request_store_data,
        input  response_valid,
        input  response_error,
        input  response_load_data,
        input  memory_valid,
        output memory_ready,
        input  memory_write,
        input  memory_address,
        input  memory_write_data,
        output memory_read_data
    );

endinterface

// File: rtl/load_store_unit.sv
// Serialises 8/16/32-bit loads and stores into little-endian byte beats on an
// 8-bit memory bus and returns extended load data or an error to the core.
module load_store_unit #(
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    load_store_unit_if.slave bus
);

    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_UBYTE  = 3'b100;
    localparam logic [2:0] F3_UHALF  = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        TRANSFER,
        RESPOND
    } state_t;

    state_t                   state;
    state_t                   state_next;

    logic                     write_q;
    logic [2:0]               funct3_q;
    logic [ADDRESS_WIDTH-1:0] base_q;
    logic [31:0]              store_data_q;
    logic                     error_q;
    logic [1:0]               beat_index;
    logic [31:0]              load_buffer;

    logic                     handshake;
    logic                     request_fault;
    logic [1:0]               last_index;
    logic                     beat_done;
    logic [31:0]              store_shifted;
    logic [31:0]              load_extended;
    logic                     unused_address_bits;

    assign unused_address_bits = ^bus.request_address[31:ADDRESS_WIDTH];

    assign handshake = bus.request_valid && (state == IDLE);
    assign beat_done = (state == TRANSFER) && bus.memory_ready;

    // Requests that can never reach memory are rejected straight to RESPOND.
    always_comb begin
        request_fault = 1'b1;
        case (bus.request_funct3)
            F3_BYTE:  request_fault = 1'b0;
            F3_HALF:  request_fault = bus.request_address[0];
            F3_WORD:  request_fault = |bus.request_address[1:0];
            F3_UBYTE: request_fault = bus.request_write;
            F3_UHALF: request_fault = bus.request_write | bus.request_address[0];
            default:  request_fault = 1'b1;
        endcase
    end

    always_comb begin
        last_index = 2'd3;
        case (funct3_q[1:0])
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (handshake) begin
                    state_next = request_fault ? RESPOND : TRANSFER;
                end
            end
            TRANSFER: begin
                if (beat_done && (beat_index == last_index)) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            base_q       <= '0;
            store_data_q <= 32'h0;
            error_q      <= 1'b0;
            beat_index   <= 2'd0;
            load_buffer  <= 32'h0;
        end else if (handshake) begin
            write_q      <= bus.request_write;
            funct3_q     <= bus.request_funct3;
            base_q       <= bus.request_address[ADDRESS_WIDTH-1:0];
            store_data_q <= bus.request_store_data;
            error_q      <= request_fault;
            beat_index   <= 2'd0;
            load_buffer  <= 32'h0;
        end else if (beat_done) begin
            if (!write_q) begin
                load_buffer[{beat_index, 3'b000} +: 8] <= bus.memory_read_data;
            end
            beat_index <= beat_index + 2'd1;
        end
    end

    assign store_shifted = store_data_q >> {beat_index, 3'b000};

    always_comb begin
        load_extended = 32'h0;
        case (funct3_q)
            F3_BYTE:  load_extended = {{24{load_buffer[7]}}, load_buffer[7:0]};
            F3_HALF:  load_extended = {{16{load_buffer[15]}}, load_buffer[15:0]};
            F3_WORD:  load_extended = load_buffer;
            F3_UBYTE: load_extended = {24'h0, load_buffer[7:0]};
            F3_UHALF: load_extended = {16'h0, load_buffer[15:0]};
            default:  load_extended = 32'h0;
        endcase
    end

    // Every output is a decode of state and latched fields, so nothing on the
    // request side reaches the memory bus combinationally.
    always_comb begin
        bus.request_ready      = (state == IDLE);
        bus.response_valid     = 1'b0;
        bus.response_error     = 1'b0;
        bus.response_load_data = 32'h0;
        bus.memory_valid       = 1'b0;
        bus.memory_write       = 1'b0;
        bus.memory_address     = '0;
        bus.memory_write_data  = 8'h00;
        if (state == TRANSFER) begin
            bus.memory_valid      = 1'b1;
            bus.memory_write      = write_q;
            bus.memory_address    = base_q + ADDRESS_WIDTH'(beat_index);
            bus.memory_write_data = store_shifted[7:0];
        end
        if (state == RESPOND) begin
            bus.response_valid = 1'b1;
            bus.response_error = error_q;
            if (!error_q && !write_q) begin
                bus.response_load_data = load_extended;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboarded
// response/beat queues checked against a simple byte-memory model.
module tb_load_store_unit;

    typedef struct {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic        err;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] data;
        int          cycle;
    } resp_t;

    typedef struct {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic clock;
    logic reset_n;

    load_store_unit_if #(.ADDRESS_WIDTH(16)) bus ();

    load_store_unit #(.ADDRESS_WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    total;
    int    bad;
    int    cycle_cnt;
    int    wait_cycles;
    int    wait_count;
    bit    prev_wait;
    logic [31:0] snap;
    logic [7:0]  mem [0:65535];
    resp_t resp_q[$];
    beat_t beat_q[$];
    vec_t  vecs[18];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    function automatic int beats_for(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    // Memory model: inserts wait states, checks beats and hold stability.
    always @(negedge clock) begin
        logic [31:0] cur;
        beat_t b;
        if (bus.memory_valid) begin
            cur = {7'b0, bus.memory_write, bus.memory_address, bus.memory_write_data};
            if (prev_wait) check_output("mem_hold", cur, snap);
            snap = cur;
            if (wait_count < wait_cycles) begin
                bus.memory_ready = 1'b0;
                wait_count++;
                prev_wait = 1'b1;
            end else begin
                bus.memory_ready = 1'b1;
                wait_count = 0;
                prev_wait = 1'b0;
                bus.memory_read_data = mem[bus.memory_address];
                if (bus.memory_write) mem[bus.memory_address] = bus.memory_write_data;
                if (beat_q.size() == 0) begin
                    check_output("beat_unexpected", {31'b0, bus.memory_valid}, 32'h0);
                end else begin
                    b = beat_q.pop_front();
                    check_output("beat_write", {31'b0, bus.memory_write}, {31'b0, b.write});
                    check_output("beat_addr", {16'h0, bus.memory_address}, {16'h0, b.addr});
                    if (b.write)
                        check_output("beat_wdata", {24'h0, bus.memory_write_data}, {24'h0, b.data});
                end
            end
        end else begin
            bus.memory_ready = (wait_cycles == 0);
            bus.memory_read_data = 8'($urandom);
            wait_count = 0;
            prev_wait = 1'b0;
        end
    end

    always @(negedge clock) begin
        resp_t e;
        if (bus.response_valid) begin
            if (resp_q.size() == 0) begin
                check_output("resp_unexpected", {31'b0, bus.response_valid}, 32'h0);
            end else begin
                e = resp_q.pop_front();
                check_output("resp_error", {31'b0, bus.response_error}, {31'b0, e.err});
                check_output("resp_data", bus.response_load_data, e.data);
                check_output("resp_cycle", cycle_cnt, e.cycle);
                check_output("beats_left", beat_q.size(), 0);
            end
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b1;
        for (int k = 0; k < 50 && !bus.request_ready; k++) @(negedge clock);
        if (!bus.request_ready) begin
            check_output("ready_timeout", {31'b0, bus.request_ready}, 32'h1);
            ok = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        bit ok;
        int n;
        logic [31:0] sh;
        @(negedge clock);
        wait_ready(ok);
        if (!ok) return;
        wait_cycles = v.waits;
        n = beats_for(v.funct3);
        bus.request_valid      = 1'b1;
        bus.request_write      = v.write;
        bus.request_funct3     = v.funct3;
        bus.request_address    = v.addr;
        bus.request_store_data = v.data;
        resp_q.push_back('{v.err, v.exp, cycle_cnt + (v.err ? 1 : n * (1 + v.waits) + 1)});
        if (!v.err) begin
            for (int i = 0; i < n; i++) begin
                sh = v.data >> (8 * i);
                beat_q.push_back('{v.write, 16'(v.addr + 32'(i)), sh[7:0]});
            end
        end
        @(negedge clock);
        bus.request_valid = 1'b0;
        bus.request_address = 32'h0;
        for (int k = 0; k < 200 && resp_q.size() != 0; k++) @(negedge clock);
        if (resp_q.size() != 0) begin
            check_output("resp_timeout", resp_q.size(), 0);
            resp_q.delete();
            beat_q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;
        total = 0;
        bad = 0;
        cycle_cnt = 0;
        wait_cycles = 0;
        wait_count = 0;
        prev_wait = 1'b0;
        snap = 32'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0203] = 8'h80;
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'hF2;

        vecs[0]  = '{1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,         0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 3'b000, 32'h0000_0203, 32'h0,         0, 1'b0, 32'hFFFF_FF80};
        vecs[3]  = '{1'b0, 3'b100, 32'h0000_0203, 32'h0,         0, 1'b0, 32'h0000_0080};
        vecs[4]  = '{1'b0, 3'b001, 32'h0000_0010, 32'h0,         2, 1'b0, 32'hFFFF_F234};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_0010, 32'h0,         1, 1'b0, 32'h0000_F234};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,         0, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,         0, 1'b1, 32'h0000_0000};
        vecs[8]  = '{1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 0, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 3'b001, 32'h0001_FFFE, 32'h0000_ABCD, 0, 1'b0, 32'h0000_0000};
        vecs[10] = '{1'b0, 3'b001, 32'h0001_FFFE, 32'h0,         0, 1'b0, 32'hFFFF_ABCD};
        vecs[11] = '{1'b0, 3'b001, 32'h0000_0011, 32'h0,         0, 1'b1, 32'h0000_0000};
        vecs[12] = '{1'b1, 3'b000, 32'h0000_0300, 32'h1234_5678, 0, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b0, 3'b100, 32'h0000_0300, 32'h0,         3, 1'b0, 32'h0000_0078};
        vecs[14] = '{1'b1, 3'b101, 32'h0000_0300, 32'h0000_1111, 0, 1'b1, 32'h0000_0000};
        vecs[15] = '{1'b0, 3'b111, 32'h0000_0300, 32'h0,         0, 1'b1, 32'h0000_0000};
        vecs[16] = '{1'b1, 3'b010, 32'h0000_0200, 32'h0102_0304, 1, 1'b0, 32'h0000_0000};
        vecs[17] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,         0, 1'b0, 32'h0102_0304};

        reset_n = 1'b0;
        bus.request_valid = 1'b0;
        bus.request_write = 1'b0;
        bus.request_funct3 = 3'b000;
        bus.request_address = 32'h0;
        bus.request_store_data = 32'h0;
        bus.memory_ready = 1'b0;
        bus.memory_read_data = 8'h00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_output("rst_request_ready", {31'b0, bus.request_ready}, 32'h1);
        check_output("rst_response_valid", {31'b0, bus.response_valid}, 32'h0);
        check_output("rst_response_error", {31'b0, bus.response_error}, 32'h0);
        check_output("rst_response_data", bus.response_load_data, 32'h0);
        check_output("rst_memory_valid", {31'b0, bus.memory_valid}, 32'h0);
        check_output("rst_memory_write", {31'b0, bus.memory_write}, 32'h0);
        check_output("rst_memory_address", {16'h0, bus.memory_address}, 32'h0);
        check_output("rst_memory_wdata", {24'h0, bus.memory_write_data}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) apply_stimulus(vecs[i]);

        // Reset while the second beat of a word load is on the bus.
        @(negedge clock);
        wait_ready(ok);
        if (ok) begin
            wait_cycles = 0;
            bus.request_valid = 1'b1;
            bus.request_write = 1'b0;
            bus.request_funct3 = 3'b010;
            bus.request_address = 32'h0000_0100;
            beat_q.push_back('{1'b0, 16'h0100, 8'h00});
            beat_q.push_back('{1'b0, 16'h0101, 8'h00});
            @(negedge clock);
            bus.request_valid = 1'b0;
            @(negedge clock);
            check_output("abort_beat2_valid", {31'b0, bus.memory_valid}, 32'h1);
            check_output("abort_beat2_addr", {16'h0, bus.memory_address}, 32'h0000_0101);
            reset_n = 1'b0;
            @(negedge clock);
            check_output("abort_memory_valid", {31'b0, bus.memory_valid}, 32'h0);
            check_output("abort_request_ready", {31'b0, bus.request_ready}, 32'h1);
            check_output("abort_response_valid", {31'b0, bus.response_valid}, 32'h0);
            reset_n = 1'b1;
            repeat (3) @(negedge clock);
            check_output("abort_beats_left", beat_q.size(), 0);
            beat_q.delete();
        end
        apply_stimulus('{1'b0, 3'b000, 32'h0000_0300, 32'h0, 0, 1'b0, 32'h0000_0078});

        repeat (5) @(negedge clock);
        check_output("final_resp_q", resp_q.size(), 0);
        check_output("final_beat_q", beat_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Executes loads and stores for the tiny RISC-V core. It sits directly downstream of the decode stage, which supplies the memory `funct3` from the `Memory_funct3` encoding. The block serialises each 8/16/32-bit access into little-endian byte beats on the 8-bit external memory bus that the Tiny Tapeout pin budget allows. It returns sign- or zero-extended load data, or an error, to the core.

## Interface
- `ADDRESS_WIDTH`, default 16: width of the external byte address; request addresses are truncated to their low `ADDRESS_WIDTH` bits.

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `request_valid`  in  1  core presents a request.
- `request_ready`  out  1  block can accept a request (IDLE only).
- `request_write`  in  1  1 = store, 0 = load.
- `request_funct3`  in  3  `Memory_funct3` code: 000 Byte, 001 Halfword, 010 Word, 100 Unsigned_Byte, 101 Unsigned_Halfword.
- `request_address`  in  32  byte address.
- `request_store_data`  in  32  store data; low bytes used for Byte and Halfword.
- `response_valid`  out  1  one-cycle completion pulse.
- `response_error`  out  1  qualifies `response_valid`; 1 = request rejected.
- `response_load_data`  out  32  extended load result; 0 for stores and errors.
- `memory_valid`  out  1  byte beat requested.
- `memory_ready`  in  1  memory completes the beat this cycle.
- `memory_write`  out  1  beat is a write.
- `memory_address`  out  `ADDRESS_WIDTH`  beat byte address.
- `memory_write_data`  out  8  write byte.
- `memory_read_data`  in  8  read byte; sampled when `memory_valid && memory_ready`.

## Operation
- States: IDLE, TRANSFER, RESPOND.
  - `request_ready` = (state == IDLE).
  - A handshake is `request_valid && request_ready`.
- On handshake, the block latches write, funct3, address, and store data, and clears the beat index and load buffer.
  - Beat count N: 1 for Byte and Unsigned_Byte, 2 for Halfword and Unsigned_Halfword, 4 for Word.
- Error conditions cause a direct move to RESPOND with no memory beat:
  - illegal funct3 (011, 110, 111);
  - store with funct3 100 or 101;
  - Halfword types with `address[0]` = 1;
  - Word with `address[1:0]` ≠ 00.
- Otherwise the block moves to TRANSFER.
- TRANSFER:
  - `memory_valid` = 1, `memory_write` = latched write, `memory_address` = base + index (modulo 2^`ADDRESS_WIDTH`), `memory_write_data` = store byte[index].
  - On `memory_ready`: load beats write `memory_read_data` into buffer byte[index], then index increments.
  - After beat N-1 completes, the block moves to RESPOND.
- RESPOND:
  - `response_valid` = 1 for exactly one cycle, then the block returns to IDLE.
  - Load data: byte/halfword sign-extended for 000/001, zero-extended for 100/101, Word unchanged.
  - Stores and errors drive 0.
- There is no response back-pressure: the core must consume the response in the pulse cycle.
- While `memory_valid` is high and `memory_ready` is low, all memory outputs are held stable.

## Timing
- Reset (`reset_n` low at an edge): the next state is IDLE.
  - Output values after reset: `request_ready` = 1; `response_valid`, `response_error`, `response_load_data`, `memory_valid`, `memory_write`, `memory_address`, `memory_write_data` all 0.
- Reset mid-TRANSFER aborts the access. `memory_valid` is 0 from the next cycle and no response is issued.
- All outputs are registered state or decodes of state and latched data; there is no combinational path from `request_*` to `memory_*`.
- Legal access with `memory_ready` tied high, handshake in cycle 0:
  - beats occupy cycles 1..N;
  - `response_valid` in cycle N+1;
  - `request_ready` is high again in cycle N+2.
- Each memory wait cycle extends the latency by one cycle.
- Error access: handshake in cycle 0, `response_valid` + `response_error` in cycle 1, ready in cycle 2.
- `request_valid` asserted outside IDLE is ignored (ready low); the core holds it.
- `memory_ready` while `memory_valid` = 0 is ignored.

## Test plan
- Word store of 0xDEADBEEF at 0x0000_0100, memory always ready: beats write 0xEF@0x100, 0xBE@0x101, 0xAD@0x102, 0xDE@0x103 in cycles 1–4; response in cycle 5 with error 0 and data 0.
- Byte load at 0x0203 with memory returning 0x80: the 000 response is 0xFFFF_FF80, the 100 response is 0x0000_0080.
- Halfword load at 0x0010 returning 0x34@0x10 and 0xF2@0x11, with `memory_ready` low for 2 cycles on each beat: the response is 0xFFFF_F234, the memory outputs stay stable during waits, and the response appears in cycle 7.
- Misaligned Word load at 0x0102, funct3 011, and a store with funct3 100: each gives `response_valid` + `response_error` in cycle 1, with no `memory_valid`.
- Address 0x0001_FFFE with `ADDRESS_WIDTH` 16, Halfword store 0xABCD: beats go to 0xFFFE and 0xFFFF.
- `reset_n` low during beat 2 of a Word load: the next cycle has `memory_valid` 0 and `request_ready` 1, no response; a following Byte load completes normally.
